seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the Basys3 four-digit seven-segment display. It sits directly downstream of the game core and consumes its four `digitN_o` nibbles and `digitN_en_o` enables. It captures them into a stable shadow copy, then scans one digit at a time with hex decoding and inter-digit blanking. It drives the board's active-low anode and cathode pins.

---
 rtl/seven_seg_scanner.sv | 91 +++++++++
 tb/tb_seven_seg_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit seven-segment scanner: synchronizes the digit bus, snapshots it once per frame,
// then drives one anode per slot with registered outputs (1-cycle latency, no backpressure).
module seven_seg_scanner #(
  parameter int TICK_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o,
  output logic       dp_o
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(TICK_CYCLES - 1);

  logic [19:0]   in_bus;
  logic [19:0]   s1, s2, s3, shadow;
  logic [CW-1:0] cyc;
  logic [1:0]    idx;
  logic          stable, frame_start, blank;
  logic [3:0]    cur_dig;
  logic          cur_en;
  logic [3:0]    anode_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign in_bus = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i,
                   digit3_i, digit2_i, digit1_i, digit0_i};

  // The shadow only updates when the synchronized bus has settled, so a frame is never torn.
  assign stable      = (s2 == s3);
  assign frame_start = (cyc == '0) && (idx == 2'd0);
  assign blank       = (BLANK_CYCLES > 0) && (int'(cyc) < BLANK_CYCLES);
  assign cur_dig     = shadow[{idx, 2'b00} +: 4];
  assign cur_en      = shadow[16 + int'(idx)];

  always_comb begin
    anode_d = 4'hF;
    seg_d   = 7'h7F;
    if (!blank) begin
      anode_d[idx] = ~cur_en;
      if (cur_en) seg_d = hex7(cur_dig);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      shadow     <= '0;
      cyc        <= '0;
      idx        <= 2'd0;
      anode_o    <= 4'hF;
      segments_o <= 7'h7F;
    end else begin
      s1 <= in_bus;
      s2 <= s1;
      s3 <= s2;
      if (frame_start && stable) shadow <= s2;
      if (cyc == CYC_LAST) begin
        cyc <= '0;
        idx <= idx + 2'd1;
      end else begin
        cyc <= cyc + CW'(1);
      end
      anode_o    <= anode_d;
      segments_o <= seg_d;
    end
  end

  assign dp_o = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with TICK_CYCLES=8 (plus a BLANK_CYCLES=0 instance).
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig [4];
  logic       en  [4];
  logic [3:0] anode, anode_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;

  int passed = 0;
  int total  = 0;
  int viol   = 0;
  int ncyc;

  typedef struct { logic [3:0] anode; logic [6:0] seg; } scan_t;
  typedef struct { logic [3:0] val;   logic [6:0] seg; } dec_t;
  scan_t scan_tab [4];
  dec_t  dec_tab  [16];

  always #5 clk = ~clk;

  seven_seg_scanner #(.TICK_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .digit0_i(dig[0]), .digit1_i(dig[1]), .digit2_i(dig[2]), .digit3_i(dig[3]),
    .digit0_en_i(en[0]), .digit1_en_i(en[1]), .digit2_en_i(en[2]), .digit3_en_i(en[3]),
    .anode_o(anode), .segments_o(seg), .dp_o(dp)
  );

  seven_seg_scanner #(.TICK_CYCLES(8), .BLANK_CYCLES(0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n),
    .digit0_i(dig[0]), .digit1_i(dig[1]), .digit2_i(dig[2]), .digit3_i(dig[3]),
    .digit0_en_i(en[0]), .digit1_en_i(en[1]), .digit2_en_i(en[2]), .digit3_en_i(en[3]),
    .anode_o(anode_nb), .segments_o(seg_nb), .dp_o(dp_nb)
  );

  // Edges since reset release: at the negedge after edge k, ncyc == k+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  always @(negedge clk) begin
    if ($countones(~anode) > 1 || $countones(~anode_nb) > 1) viol++;
    if (anode == 4'hF && seg != 7'h7F) viol++;
    if (anode_nb == 4'hF && seg_nb != 7'h7F) viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ncyc - 1);
  endtask

  task automatic goto(input int k);
    int n = 0;
    while (ncyc != k + 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (ncyc != k + 1) begin
      total++;
      $display("FAIL goto: edge %0d not reached, at %0d", k, ncyc - 1);
    end
  endtask

  task automatic set_bus(input logic [3:0] v3, v2, v1, v0, input logic [3:0] ens);
    dig[3] = v3; dig[2] = v2; dig[1] = v1; dig[0] = v0;
    for (int i = 0; i < 4; i++) en[i] = ens[i];
  endtask

  initial begin
    int m, r, lit, d;
    logic [3:0] ea;
    logic [6:0] es;

    scan_tab[0] = '{4'hE, 7'h0E}; scan_tab[1] = '{4'hD, 7'h08};
    scan_tab[2] = '{4'hB, 7'h24}; scan_tab[3] = '{4'h7, 7'h79};
    dec_tab[0]  = '{4'h0, 7'h40}; dec_tab[1]  = '{4'h1, 7'h79};
    dec_tab[2]  = '{4'h2, 7'h24}; dec_tab[3]  = '{4'h3, 7'h30};
    dec_tab[4]  = '{4'h4, 7'h19}; dec_tab[5]  = '{4'h5, 7'h12};
    dec_tab[6]  = '{4'h6, 7'h02}; dec_tab[7]  = '{4'h7, 7'h78};
    dec_tab[8]  = '{4'h8, 7'h00}; dec_tab[9]  = '{4'h9, 7'h10};
    dec_tab[10] = '{4'hA, 7'h08}; dec_tab[11] = '{4'hB, 7'h03};
    dec_tab[12] = '{4'hC, 7'h46}; dec_tab[13] = '{4'hD, 7'h21};
    dec_tab[14] = '{4'hE, 7'h06}; dec_tab[15] = '{4'hF, 7'h0E};

    // Reset held with digits 3..0 = 1,2,A,F all enabled
    rst_n = 1'b0;
    set_bus(4'h1, 4'h2, 4'hA, 4'hF, 4'hF);
    #12;
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0 loads an all-zero shadow: dark
    goto(2);
    check("frame0_dark_anode", 32'(anode), 32'hF);

    // Static scan, frames 2 and 3, both instances
    for (int k = 64; k < 128; k++) begin
      goto(k);
      d  = (k / 8) % 4;
      ea = ((k % 8) < 2) ? 4'hF : scan_tab[d].anode;
      es = ((k % 8) < 2) ? 7'h7F : scan_tab[d].seg;
      check("scan_anode", 32'(anode), 32'(ea));
      check("scan_seg", 32'(seg), 32'(es));
      check("noblank_anode", 32'(anode_nb), 32'(scan_tab[d].anode));
      check("noblank_seg", 32'(seg_nb), 32'(scan_tab[d].seg));
    end
    check("dp_const", 32'(dp), 32'h1);

    // Hex decode table on digit 0 only; digit 1 slot must stay dark
    for (int i = 0; i < 16; i++) begin
      m = ncyc / 32 + 2;
      goto(32 * m - 4);
      set_bus(dec_tab[i].val, dec_tab[i].val, dec_tab[i].val, dec_tab[i].val, 4'b0001);
      goto(32 * m + 2);
      check("decode_anode", 32'(anode), 32'hE);
      check("decode_seg", 32'(seg), 32'(dec_tab[i].seg));
      goto(32 * m + 10);
      check("decode_masked_anode", 32'(anode), 32'hF);
      check("decode_masked_seg", 32'(seg), 32'h7F);
    end

    // Enable masking: only digit 1 = 8 over a whole frame
    m = ncyc / 32 + 2;
    goto(32 * m - 4);
    set_bus(4'h3, 4'h3, 4'h8, 4'h3, 4'b0010);
    lit = 0;
    for (int k = 32 * m; k < 32 * m + 32; k++) begin
      goto(k);
      r = k % 32;
      if (r / 8 == 1 && r % 8 >= 2) begin
        ea = 4'hD; es = 7'h00;
      end else begin
        ea = 4'hF; es = 7'h7F;
      end
      if (anode == 4'hD) lit++;
      check("mask_anode", 32'(anode), 32'(ea));
      check("mask_seg", 32'(seg), 32'(es));
    end
    check("mask_lit_cycles", 32'(lit), 32'd6);

    // Change on the frame-start sample cycle: old value survives one more frame
    m = ncyc / 32 + 2;
    goto(32 * m - 4);
    set_bus(4'h0, 4'h0, 4'h0, 4'h5, 4'b0001);
    goto(32 * (m + 1) - 3);
    dig[0] = 4'h9;
    goto(32 * (m + 1) + 2);
    check("torn_keep_old", 32'(seg), 32'h12);
    goto(32 * (m + 2) + 2);
    check("torn_new", 32'(seg), 32'h10);

    // Reset mid-scan while digit 0 is lit
    goto(32 * (m + 2) + 4);
    check("pre_reset_anode", 32'(anode), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_anode", 32'(anode), 32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    goto(2);
    check("post_reset_dark", 32'(anode), 32'hF);
    goto(34);
    check("post_reset_anode", 32'(anode), 32'hE);
    check("post_reset_seg", 32'(seg), 32'h10);

    // Random digits and enables; invariants watched by the monitor
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < 4; i++) begin
          dig[i] = 4'($urandom_range(15));
          en[i]  = 1'($urandom_range(1));
        end
      end
    end
    check("invariants", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
